// File: rtl/store_commit_queue.sv
// store_commit_queue: receives stores from the store buffer, holds each one
// until the ROB commits its slot, then writes committed stores to memory in
// commit order through a req/ack handshake.
// Optional store-to-load forwarding is enabled with `define STQ_FWD_EN.
module store_commit_queue #(
  parameter int DEPTH = 8,
  parameter int IDXW  = 3,
  parameter int ROBW  = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            st_req,
  input  logic [28:0]     st_addr_in,
  input  logic [31:0]     st_data_in,
  output logic            st_grant,
  input  logic            commit,
  input  logic [ROBW-1:0] commit_slot,
  input  logic            flush,
  output logic            mem_req,
  output logic [22:0]     mem_addr,
  output logic            mem_io,
  output logic [31:0]     mem_data,
  input  logic            mem_ack,
  output logic            full,
  output logic [IDXW:0]   count,
  output logic            commit_miss,
  input  logic [22:0]     ld_addr,
  input  logic            ld_io,
  output logic            ld_fwd_hit,
  output logic [31:0]     ld_fwd_data
);

  typedef enum logic [1:0] {E_FREE, E_PEND, E_COMM} ent_state_e;

  ent_state_e      r_state [DEPTH];
  logic [ROBW-1:0] r_tag   [DEPTH];
  logic            r_memio [DEPTH];
  logic [22:0]     r_addr  [DEPTH];
  logic [31:0]     r_data  [DEPTH];
  logic [IDXW-1:0] r_fifo  [DEPTH];
  logic [IDXW-1:0] r_head, r_tail;
  logic [IDXW:0]   r_fcnt;
  logic [IDXW:0]   r_count;
  logic            r_full;
  logic            r_commit_miss;

  ent_state_e      w_state_nxt [DEPTH];
  logic            w_free_found, w_cam_hit, w_new_commit, w_push, w_pop;
  logic [IDXW-1:0] w_free_idx, w_cam_idx, w_push_idx, w_head_idx;
  logic [IDXW:0]   w_count_nxt;
  logic [ROBW-1:0] w_new_tag;

  assign w_new_tag   = st_addr_in[24 +: ROBW];
  assign st_grant    = st_req & ~r_full & ~flush;
  assign full        = r_full;
  assign count       = r_count;
  assign commit_miss = r_commit_miss;
  assign mem_req     = (r_fcnt != '0);
  assign w_pop       = mem_req & mem_ack;
  assign w_head_idx  = r_fifo[r_head];
  assign mem_addr    = r_addr[w_head_idx];
  assign mem_io      = r_memio[w_head_idx];
  assign mem_data    = r_data[w_head_idx];

  // Lowest-index free entry and CAM lookup of the committing slot
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    w_cam_hit    = 1'b0;
    w_cam_idx    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!w_free_found && r_state[IDXW'(i)] == E_FREE) begin
        w_free_found = 1'b1;
        w_free_idx   = IDXW'(i);
      end
      if (commit && !w_cam_hit && r_state[IDXW'(i)] == E_PEND &&
          r_tag[IDXW'(i)] == commit_slot) begin
        w_cam_hit = 1'b1;
        w_cam_idx = IDXW'(i);
      end
    end
    w_new_commit = st_grant & commit & ~w_cam_hit & (w_new_tag == commit_slot);
    w_push       = w_cam_hit | w_new_commit;
    w_push_idx   = w_cam_hit ? w_cam_idx : w_free_idx;
  end

  // Next entry states; commit is applied before flush so a same-cycle commit survives
  always_comb begin
    w_state_nxt = r_state;
    if (w_pop)
      w_state_nxt[w_head_idx] = E_FREE;
    if (st_grant)
      w_state_nxt[w_free_idx] = w_new_commit ? E_COMM : E_PEND;
    if (w_cam_hit)
      w_state_nxt[w_cam_idx] = E_COMM;
    if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        if (w_state_nxt[IDXW'(i)] == E_PEND)
          w_state_nxt[IDXW'(i)] = E_FREE;
    end
    w_count_nxt = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      if (w_state_nxt[IDXW'(i)] != E_FREE)
        w_count_nxt = w_count_nxt + (IDXW+1)'(1);
  end

  // Entry storage, drain FIFO and registered status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_state[IDXW'(i)] <= E_FREE;
        r_tag[IDXW'(i)]   <= '0;
        r_memio[IDXW'(i)] <= 1'b0;
        r_addr[IDXW'(i)]  <= '0;
        r_data[IDXW'(i)]  <= '0;
        r_fifo[IDXW'(i)]  <= '0;
      end
      r_head        <= '0;
      r_tail        <= '0;
      r_fcnt        <= '0;
      r_count       <= '0;
      r_full        <= 1'b0;
      r_commit_miss <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (st_grant) begin
        r_tag[w_free_idx]   <= w_new_tag;
        r_memio[w_free_idx] <= st_addr_in[23];
        r_addr[w_free_idx]  <= st_addr_in[22:0];
        r_data[w_free_idx]  <= st_data_in;
      end
      if (w_push) begin
        r_fifo[r_tail] <= w_push_idx;
        r_tail <= (r_tail == IDXW'(DEPTH-1)) ? '0 : r_tail + IDXW'(1);
      end
      if (w_pop)
        r_head <= (r_head == IDXW'(DEPTH-1)) ? '0 : r_head + IDXW'(1);
      case ({w_push, w_pop})
        2'b10:   r_fcnt <= r_fcnt + (IDXW+1)'(1);
        2'b01:   r_fcnt <= r_fcnt - (IDXW+1)'(1);
        default: r_fcnt <= r_fcnt;
      endcase
      r_count       <= w_count_nxt;
      r_full        <= (w_count_nxt == (IDXW+1)'(DEPTH));
      r_commit_miss <= commit & ~w_push;
    end
  end

`ifdef STQ_FWD_EN
  // Forward from the youngest committed store: scan head->tail, last match wins
  always_comb begin
    ld_fwd_hit  = 1'b0;
    ld_fwd_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      int unsigned     p;
      logic [IDXW-1:0] e;
      p = (32'(r_head) + i) % DEPTH;
      e = r_fifo[IDXW'(p)];
      if ((IDXW+1)'(i) < r_fcnt && r_state[e] == E_COMM &&
          r_addr[e] == ld_addr && r_memio[e] == ld_io) begin
        ld_fwd_hit  = 1'b1;
        ld_fwd_data = r_data[e];
      end
    end
  end
`else
  logic w_unused_ld;
  assign w_unused_ld = ^{ld_addr, ld_io};
  assign ld_fwd_hit  = 1'b0;
  assign ld_fwd_data = '0;
`endif

endmodule

// File: tb/tb_store_commit_queue.sv
// Randomized + directed bench for store_commit_queue against a queue-based
// reference model (pending list + commit-ordered drain queue).
module tb_store_commit_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_req;
  logic [28:0] st_addr_in;
  logic [31:0] st_data_in;
  logic        st_grant;
  logic        commit;
  logic [4:0]  commit_slot;
  logic        flush;
  logic        mem_req;
  logic [22:0] mem_addr;
  logic        mem_io;
  logic [31:0] mem_data;
  logic        mem_ack;
  logic        full;
  logic [3:0]  count;
  logic        commit_miss;
  logic [22:0] ld_addr;
  logic        ld_io;
  logic        ld_fwd_hit;
  logic [31:0] ld_fwd_data;

  store_commit_queue #(.DEPTH(8), .IDXW(3), .ROBW(5)) dut (
    .clk(clk), .rst_n(rst_n), .st_req(st_req), .st_addr_in(st_addr_in),
    .st_data_in(st_data_in), .st_grant(st_grant), .commit(commit),
    .commit_slot(commit_slot), .flush(flush), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_io(mem_io), .mem_data(mem_data),
    .mem_ack(mem_ack), .full(full), .count(count), .commit_miss(commit_miss),
    .ld_addr(ld_addr), .ld_io(ld_io), .ld_fwd_hit(ld_fwd_hit),
    .ld_fwd_data(ld_fwd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  slot;
    logic        io;
    logic [22:0] addr;
    logic [31:0] data;
  } st_t;

  st_t pend[$];
  st_t cq[$];
  int  m_count;
  bit  m_full;
  bit  m_miss;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit req, input logic [4:0] slot, input logic io,
                       input logic [22:0] a, input logic [31:0] d, input bit c,
                       input logic [4:0] cs, input bit fl, input bit ack);
    st_req      = req;
    st_addr_in  = {slot, io, a};
    st_data_in  = d;
    commit      = c;
    commit_slot = cs;
    flush       = fl;
    mem_ack     = ack;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 23'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic model_clear();
    pend.delete();
    cq.delete();
    m_count = 0;
    m_full  = 1'b0;
    m_miss  = 1'b0;
  endtask

  // Called at a negedge with inputs already driven: check, advance model, wait one cycle
  task automatic cycle();
    bit   g, pop, miss, direct, found, fhit;
    int   fk;
    st_t  nw;
    logic [31:0] fdata;
    #1;
    g = st_req && !m_full && !flush;
    check("st_grant", 32'(st_grant), 32'(g));
    check("count", 32'(count), 32'(m_count));
    check("full", 32'(full), 32'(m_full));
    check("commit_miss", 32'(commit_miss), 32'(m_miss));
    check("mem_req", 32'(mem_req), 32'(cq.size() > 0));
    if (cq.size() > 0) begin
      check("mem_addr", 32'(mem_addr), 32'(cq[0].addr));
      check("mem_io", 32'(mem_io), 32'(cq[0].io));
      check("mem_data", mem_data, cq[0].data);
    end
    fhit  = 1'b0;
    fdata = 32'd0;
`ifdef STQ_FWD_EN
    for (int k = 0; k < cq.size(); k++)
      if (cq[k].addr == ld_addr && cq[k].io == ld_io) begin
        fhit  = 1'b1;
        fdata = cq[k].data;
      end
`endif
    check("ld_fwd_hit", 32'(ld_fwd_hit), 32'(fhit));
    check("ld_fwd_data", ld_fwd_data, fdata);

    nw.slot = st_addr_in[28:24];
    nw.io   = st_addr_in[23];
    nw.addr = st_addr_in[22:0];
    nw.data = st_data_in;
    pop    = (cq.size() > 0) && mem_ack;
    miss   = 1'b0;
    direct = 1'b0;
    found  = 1'b0;
    fk     = 0;
    if (pop) void'(cq.pop_front());
    if (commit) begin
      for (int k = 0; k < pend.size(); k++)
        if (!found && pend[k].slot == commit_slot) begin
          found = 1'b1;
          fk    = k;
        end
      if (found) begin
        cq.push_back(pend[fk]);
        pend.delete(fk);
      end else if (g && nw.slot == commit_slot) direct = 1'b1;
      else miss = 1'b1;
    end
    if (g) begin
      if (direct) cq.push_back(nw);
      else pend.push_back(nw);
    end
    if (flush) pend.delete();
    m_count = pend.size() + cq.size();
    m_full  = (m_count == 8);
    m_miss  = miss;
    @(negedge clk);
  endtask

  function automatic bit in_pend(input logic [4:0] s);
    foreach (pend[k]) if (pend[k].slot == s) return 1'b1;
    return 1'b0;
  endfunction

  task automatic flush_and_drain();
    drive(1'b0, 5'd0, 1'b0, 23'd0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    cycle();
    for (int k = 0; k < 20 && cq.size() > 0; k++) begin
      drive(1'b0, 5'd0, 1'b0, 23'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b1);
      cycle();
    end
    check("drain_done", 32'(cq.size()), 32'd0);
    idle();
  endtask

  initial begin
    rst_n   = 1'b0;
    ld_addr = 23'd0;
    ld_io   = 1'b0;
    idle();
    model_clear();
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset then idle
    repeat (2) cycle();
    check("idle_grant", 32'(st_grant), 32'd0);

    // Single store, commit two cycles later, delayed ack
    drive(1'b1, 5'd3, 1'b0, 23'h000100, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 1'b0); cycle();
    idle(); cycle();
    drive(1'b0, 5'd0, 1'b0, 23'd0, 32'd0, 1'b1, 5'd3, 1'b0, 1'b0); cycle();
    check("t2_mem_req", 32'(mem_req), 32'd1);
    check("t2_mem_addr", 32'(mem_addr), 32'h00000100);
    check("t2_mem_data", mem_data, 32'hDEADBEEF);
    idle(); repeat (3) cycle();
    check("t2_hold_data", mem_data, 32'hDEADBEEF);
    drive(1'b0, 5'd0, 1'b0, 23'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b1); cycle();
    idle(); cycle();
    check("t2_count0", 32'(count), 32'd0);

    // Out-of-order accept 7,5,6; commit 5,6,7 -> drains 5,6,7
    drive(1'b1, 5'd7, 1'b0, 23'h000700, 32'h77, 1'b0, 5'd0, 1'b0, 1'b0); cycle();
    drive(1'b1, 5'd5, 1'b1, 23'h000500, 32'h55, 1'b0, 5'd0, 1'b0, 1'b0); cycle();
    drive(1'b1, 5'd6, 1'b0, 23'h000600, 32'h66, 1'b0, 5'd0, 1'b0, 1'b0); cycle();
    drive(1'b0, 5'd0, 1'b0, 23'd0, 32'd0, 1'b1, 5'd5, 1'b0, 1'b0); cycle();
    drive(1'b0, 5'd0, 1'b0, 23'd0, 32'd0, 1'b1, 5'd6, 1'b0, 1'b0); cycle();
    drive(1'b0, 5'd0, 1'b0, 23'd0, 32'd0, 1'b1, 5'd7, 1'b0, 1'b0); cycle();
    check("t3_first", 32'(mem_addr), 32'h00000500);
    flush_and_drain();

    // Fill all 8 entries, then free one
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 5'(16 + i), 1'b0, 23'(i), 32'(i * 3), 1'b0, 5'd0, 1'b0, 1'b0);
      cycle();
    end
    check("t4_full", 32'(full), 32'd1);
    drive(1'b1, 5'd30, 1'b0, 23'h55, 32'h1, 1'b1, 5'd16, 1'b0, 1'b0);
    #1 check("t4_no_grant", 32'(st_grant), 32'd0);
    cycle();
    drive(1'b1, 5'd30, 1'b0, 23'h55, 32'h1, 1'b0, 5'd0, 1'b0, 1'b1);
    #1 check("t4_no_grant_ack", 32'(st_grant), 32'd0);
    cycle();
    drive(1'b1, 5'd30, 1'b0, 23'h55, 32'h1, 1'b0, 5'd0, 1'b0, 1'b0);
    #1 check("t4_grant_resumes", 32'(st_grant), 32'd1);
    cycle();
    flush_and_drain();

    // Flush with same-cycle commit
    drive(1'b1, 5'd8, 1'b0, 23'h80, 32'h8, 1'b0, 5'd0, 1'b0, 1'b0); cycle();
    drive(1'b1, 5'd9, 1'b0, 23'h90, 32'h9, 1'b1, 5'd8, 1'b0, 1'b0); cycle();
    drive(1'b1, 5'd10, 1'b0, 23'hA0, 32'hA, 1'b0, 5'd0, 1'b0, 1'b0); cycle();
    drive(1'b0, 5'd0, 1'b0, 23'd0, 32'd0, 1'b1, 5'd9, 1'b1, 1'b0); cycle();
    check("t5_count2", 32'(count), 32'd2);
    flush_and_drain();

    // Commit of a never-accepted slot
    drive(1'b0, 5'd0, 1'b0, 23'd0, 32'd0, 1'b1, 5'd12, 1'b0, 1'b0); cycle();
    check("t6_miss", 32'(commit_miss), 32'd1);
    idle(); cycle();
    check("t6_miss_clear", 32'(commit_miss), 32'd0);

    // Forwarding: two committed stores to the same address
    ld_addr = 23'h40;
    ld_io   = 1'b0;
    drive(1'b1, 5'd1, 1'b0, 23'h40, 32'h11, 1'b1, 5'd1, 1'b0, 1'b0); cycle();
    drive(1'b1, 5'd2, 1'b0, 23'h40, 32'h22, 1'b1, 5'd2, 1'b0, 1'b0); cycle();
    idle(); #1;
`ifdef STQ_FWD_EN
    check("t7_fwd_hit", 32'(ld_fwd_hit), 32'd1);
    check("t7_fwd_data", ld_fwd_data, 32'h22);
`else
    check("t7_fwd_hit", 32'(ld_fwd_hit), 32'd0);
    check("t7_fwd_data", ld_fwd_data, 32'h0);
`endif
    cycle();
    flush_and_drain();

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      bit          req, c, fl, ack, ok;
      logic [4:0]  s, cs;
      int          r;
      req = ($urandom_range(0, 99) < 60);
      ok  = 1'b0;
      s   = 5'd0;
      for (int t = 0; t < 64 && !ok; t++) begin
        s  = 5'($urandom_range(0, 31));
        ok = !in_pend(s);
      end
      if (!ok) req = 1'b0;
      c  = ($urandom_range(0, 99) < 45);
      r  = int'($urandom_range(0, 99));
      if (pend.size() > 0 && r < 70) cs = pend[$urandom_range(0, pend.size() - 1)].slot;
      else if (r < 85) cs = s;
      else cs = 5'($urandom_range(0, 31));
      fl  = ($urandom_range(0, 99) < 5);
      ack = ($urandom_range(0, 99) < 55);
      ld_addr = 23'($urandom_range(0, 7));
      ld_io   = 1'($urandom_range(0, 1));
      drive(req, s, 1'($urandom_range(0, 1)), 23'($urandom_range(0, 7)),
            $urandom, c, cs, fl, ack);
      cycle();
    end

    // Reset in the middle of a handshake
    drive(1'b1, 5'd4, 1'b0, 23'h123, 32'h4444, 1'b1, 5'd4, 1'b1, 1'b0);
    flush = 1'b0;
    cycle();
    idle();
    check("t8_req_before", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t8_rst_mem_req", 32'(mem_req), 32'd0);
    check("t8_rst_count", 32'(count), 32'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
